// File: rtl/mux_ab_bus_sequencer.sv
// Round-robin arbiter/sequencer for the registered A/B source mux feeding the register-file write path.
// Grants one of four requesters, waits SETTLE cycles for the mux output, then strobes WriteEn/Ack.
module mux_ab_bus_sequencer #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] Req,
  output logic [1:0] MuxSel,
  output logic       WriteEn,
  output logic [3:0] Ack,
  output logic       Busy
);

  localparam int unsigned NREQ  = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    WRITE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   g_q, g_d;
  logic [IDX_W-1:0]   p_q, p_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   mux_sel_q, mux_sel_d;
  logic               write_en_q, write_en_d;
  logic [NREQ-1:0]    ack_q, ack_d;
  logic               busy_q, busy_d;

  logic [NREQ-1:0]    grant_oh_c;
  logic [NREQ-1:0]    cand_c;
  logic               pick_found_c;
  logic [IDX_W-1:0]   pick_idx_c;

  // First set bit of cand scanning upward from ptr with wrap; result is {found, index}.
  function automatic logic [IDX_W:0] rr_pick(input logic [NREQ-1:0] cand,
                                             input logic [IDX_W-1:0] ptr);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] idx;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr + IDX_W'(k);
      if (cand[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // The requester being acknowledged is masked out of the WRITE-cycle arbitration.
  always_comb begin
    grant_oh_c = NREQ'(1) << g_q;
    cand_c     = (state_q == WRITE) ? (Req & ~grant_oh_c) : Req;
    {pick_found_c, pick_idx_c} = rr_pick(cand_c, p_q);
  end

  // State register and registered datapath/outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      g_q        <= '0;
      p_q        <= '0;
      cnt_q      <= '0;
      mux_sel_q  <= '0;
      write_en_q <= 1'b0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      g_q        <= g_d;
      p_q        <= p_d;
      cnt_q      <= cnt_d;
      mux_sel_q  <= mux_sel_d;
      write_en_q <= write_en_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_found_c) state_d = SELECT;
      SELECT:  if (cnt_q == '0) state_d = WRITE;
      WRITE:   state_d = pick_found_c ? SELECT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the grant, pointer, settle counter and registered outputs.
  always_comb begin
    g_d        = g_q;
    p_d        = p_q;
    cnt_d      = cnt_q;
    mux_sel_d  = mux_sel_q;
    write_en_d = 1'b0;
    ack_d      = '0;
    busy_d     = busy_q;
    unique case (state_q)
      IDLE, WRITE: begin
        if (pick_found_c) begin
          g_d       = pick_idx_c;
          mux_sel_d = pick_idx_c;
          p_d       = pick_idx_c + IDX_W'(1);
          cnt_d     = CNT_W'(SETTLE - 1);
          busy_d    = 1'b1;
        end else begin
          busy_d    = 1'b0;
        end
      end
      SELECT: begin
        if (cnt_q == '0) begin
          write_en_d = 1'b1;
          ack_d      = grant_oh_c;
        end else begin
          cnt_d      = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign MuxSel  = mux_sel_q;
  assign WriteEn = write_en_q;
  assign Ack     = ack_q;
  assign Busy    = busy_q;

endmodule

// File: tb/tb_mux_ab_bus_sequencer.sv
// Bench for mux_ab_bus_sequencer: SETTLE=1 and SETTLE=3 instances checked every cycle against a
// transfer-level model, plus directed literal expectations.
module tb_mux_ab_bus_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] req1, req3;
  logic [1:0] sel1, sel3;
  logic       we1, we3;
  logic [3:0] ack1, ack3;
  logic       busy1, busy3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  mux_ab_bus_sequencer #(.SETTLE(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .Req(req1),
    .MuxSel(sel1), .WriteEn(we1), .Ack(ack1), .Busy(busy1)
  );

  mux_ab_bus_sequencer #(.SETTLE(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .Req(req3),
    .MuxSel(sel3), .WriteEn(we3), .Ack(ack3), .Busy(busy3)
  );

  // Model state per instance: transfer in flight, cycles since grant, granted index, pointer.
  int m_active[2];
  int m_age[2];
  int m_g[2];
  int m_sel[2];
  int m_ptr[2];
  int settle[2] = '{1, 3};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_grant(input int i, input logic [3:0] cand);
    int  idx;
    bit  found;
    found = 0;
    for (int k = 0; k < 4; k++) begin
      idx = (m_ptr[i] + k) % 4;
      if (!found && cand[idx]) begin
        found       = 1;
        m_g[i]      = idx;
        m_sel[i]    = idx;
        m_ptr[i]    = (idx + 1) % 4;
        m_age[i]    = 0;
        m_active[i] = 1;
      end
    end
  endtask

  task automatic m_step(input int i, input logic rn, input logic [3:0] r);
    logic [3:0] cand;
    if (!rn) begin
      m_active[i] = 0; m_age[i] = 0; m_g[i] = 0; m_sel[i] = 0; m_ptr[i] = 0;
    end else if (m_active[i] == 0) begin
      if (r != 4'b0000) m_grant(i, r);
    end else if (m_age[i] == settle[i]) begin
      cand = r & ~(4'b0001 << m_g[i]);
      if (cand != 4'b0000) m_grant(i, cand);
      else m_active[i] = 0;
    end else begin
      m_age[i]++;
    end
  endtask

  task automatic m_check(input int i, input logic [1:0] s, input logic w,
                         input logic [3:0] a, input logic b);
    logic       e_we;
    logic [3:0] e_ack;
    e_we  = (m_active[i] != 0) && (m_age[i] == settle[i]);
    e_ack = e_we ? (4'b0001 << m_g[i]) : 4'b0000;
    chk($sformatf("model_s%0d_sel", settle[i]), 32'(s), 32'(m_sel[i]));
    chk($sformatf("model_s%0d_we", settle[i]), 32'(w), 32'(e_we));
    chk($sformatf("model_s%0d_ack", settle[i]), 32'(a), 32'(e_ack));
    chk($sformatf("model_s%0d_busy", settle[i]), 32'(b), 32'(m_active[i] != 0));
  endtask

  // Advance the model on each edge, then compare both instances just after it.
  always @(posedge clock) begin
    m_step(0, reset_n, req1);
    m_step(1, reset_n, req3);
    #1;
    m_check(0, sel1, we1, ack1, busy1);
    m_check(1, sel3, we3, ack3, busy3);
  end

  // Requesters drop their Req bit once they see the matching Ack.
  task automatic nedge();
    @(negedge clock);
    req1 = req1 & ~ack1;
    req3 = req3 & ~ack3;
  endtask

  logic [3:0] vec [8] = '{4'b0110, 4'b1001, 4'b1111, 4'b0000,
                          4'b0011, 4'b1100, 4'b0101, 4'b1010};

  initial begin
    reset_n = 1'b0; req1 = '0; req3 = '0;
    nedge(); nedge();
    chk("rst_sel", 32'(sel1), 32'd0);
    chk("rst_we", 32'(we1), 32'd0);
    chk("rst_ack", 32'(ack1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    reset_n = 1'b1;

    // Single request
    req1 = 4'b0001;
    nedge(); chk("t1_sel", 32'(sel1), 32'd0); chk("t1_busy", 32'(busy1), 32'd1);
    chk("t1_we_early", 32'(we1), 32'd0);
    nedge(); chk("t1_we", 32'(we1), 32'd1); chk("t1_ack", 32'(ack1), 32'b0001);
    nedge(); chk("t1_we_off", 32'(we1), 32'd0); chk("t1_idle", 32'(busy1), 32'd0);

    // All requesting from a fresh pointer
    reset_n = 1'b0; nedge(); reset_n = 1'b1;
    req1 = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      nedge();
      chk($sformatf("t2_sel%0d", k), 32'(sel1), 32'(k));
      chk($sformatf("t2_busy%0d", k), 32'(busy1), 32'd1);
      chk($sformatf("t2_we_off%0d", k), 32'(we1), 32'd0);
      nedge();
      chk($sformatf("t2_ack%0d", k), 32'(ack1), 32'(4'b0001 << k));
      chk($sformatf("t2_we%0d", k), 32'(we1), 32'd1);
    end
    nedge(); chk("t2_idle", 32'(busy1), 32'd0);

    // Rotation after a grant to requester 2
    req1 = 4'b0100;
    nedge(); chk("t3_sel_a", 32'(sel1), 32'd2);
    nedge(); chk("t3_ack_a", 32'(ack1), 32'b0100);
    nedge(); chk("t3_idle_a", 32'(busy1), 32'd0);
    req1 = 4'b0101;
    nedge(); chk("t3_sel_b", 32'(sel1), 32'd0);
    nedge(); chk("t3_ack_b", 32'(ack1), 32'b0001);
    nedge(); chk("t3_sel_c", 32'(sel1), 32'd2); chk("t3_busy_c", 32'(busy1), 32'd1);
    nedge(); chk("t3_ack_c", 32'(ack1), 32'b0100);
    nedge(); chk("t3_idle_c", 32'(busy1), 32'd0);

    // Request dropped after one cycle is still completed
    req1 = 4'b1000;
    nedge(); req1 = 4'b0000; chk("t4_sel", 32'(sel1), 32'd3);
    nedge(); chk("t4_we", 32'(we1), 32'd1); chk("t4_ack", 32'(ack1), 32'b1000);
    chk("t4_sel_hold", 32'(sel1), 32'd3);
    nedge(); chk("t4_idle", 32'(busy1), 32'd0);

    // Reset during SELECT aborts the transfer
    req1 = 4'b0100;
    nedge(); chk("t5_busy", 32'(busy1), 32'd1);
    reset_n = 1'b0; req1 = 4'b0000;
    nedge();
    chk("t5_rst_we", 32'(we1), 32'd0); chk("t5_rst_ack", 32'(ack1), 32'd0);
    chk("t5_rst_sel", 32'(sel1), 32'd0); chk("t5_rst_busy", 32'(busy1), 32'd0);
    reset_n = 1'b1; req1 = 4'b0010;
    nedge(); chk("t5_sel", 32'(sel1), 32'd1); chk("t5_busy2", 32'(busy1), 32'd1);
    nedge(); chk("t5_ack", 32'(ack1), 32'b0010);
    nedge(); chk("t5_idle", 32'(busy1), 32'd0);

    // SETTLE=3 instance
    req3 = 4'b0100;
    for (int k = 1; k <= 3; k++) begin
      nedge();
      chk($sformatf("t6_sel%0d", k), 32'(sel3), 32'd2);
      chk($sformatf("t6_busy%0d", k), 32'(busy3), 32'd1);
      chk($sformatf("t6_we_off%0d", k), 32'(we3), 32'd0);
    end
    nedge(); chk("t6_we", 32'(we3), 32'd1); chk("t6_ack", 32'(ack3), 32'b0100);
    chk("t6_sel_hold", 32'(sel3), 32'd2);
    nedge(); chk("t6_idle", 32'(busy3), 32'd0);

    // Overlapping request patterns on both instances
    for (int k = 0; k < 8; k++) begin
      req1 = req1 | vec[k];
      req3 = req3 | vec[k];
      nedge(); nedge(); nedge();
    end
    for (int k = 0; k < 60; k++) nedge();
    chk("drain_busy1", 32'(busy1), 32'd0);
    chk("drain_busy3", 32'(busy3), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
